// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus of the instruction fetch unit: instruction memory port,
// ID feedback (stall/redirect) and the IF/ID pipeline register outputs.
interface instr_fetch_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic                   stall;
  logic                   redirect;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic [INSTR_WIDTH-1:0] if_id_instr;
  logic [3:0]             if_id_opcode;
  logic [PC_WIDTH-1:0]    if_id_pc_plus1;
  logic                   if_id_valid;
  logic [15:0]            issued_count;

  // Handshake: if_id_valid=1 marks a real instruction in IF/ID, 0 a bubble.
  // stall=1 freezes PC and IF/ID; redirect=1 (with redirect_pc) overrides stall.
  modport master (
    output imem_addr, if_id_instr, if_id_opcode, if_id_pc_plus1,
           if_id_valid, issued_count,
    input  imem_data, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, if_id_instr, if_id_opcode, if_id_pc_plus1,
           if_id_valid, issued_count,
    output imem_data, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Pipeline front end: PC register, instruction fetch and IF/ID register,
// with ID-driven stall and one-bubble redirect flush.
module instr_fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int RESET_PC    = 0
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus,
  output logic [1:0]          state_o
);
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);

  state_e                 state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [3:0]             opcode_q;
  logic [PC_WIDTH-1:0]    pc_plus1_q;
  logic                   valid_q;
  logic [15:0]            count_q;

  logic [PC_WIDTH-1:0]    pc_plus1_d;
  logic [15:0]            count_d;

  // PC increment wraps naturally; the issue counter sticks at all-ones.
  assign pc_plus1_d = pc_q + 1'b1;
  assign count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RST_PC;
      instr_q    <= '0;
      opcode_q   <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          instr_q    <= bus.imem_data;
          opcode_q   <= bus.imem_data[INSTR_WIDTH-1 -: 4];
          pc_plus1_q <= pc_plus1_d;
          valid_q    <= 1'b1;
          pc_q       <= pc_plus1_d;
          count_q    <= count_d;
          state_q    <= RUN;
        end
        default: begin
          if (bus.redirect) begin
            pc_q       <= bus.redirect_pc;
            instr_q    <= '0;
            opcode_q   <= '0;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
            state_q    <= FLUSH;
          end else if (!bus.stall) begin
            instr_q    <= bus.imem_data;
            opcode_q   <= bus.imem_data[INSTR_WIDTH-1 -: 4];
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= 1'b1;
            pc_q       <= pc_plus1_d;
            count_q    <= count_d;
            state_q    <= RUN;
          end
          // A stall keeps every register, so a flush bubble stays a bubble.
        end
      endcase
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_opcode   = opcode_q;
  assign bus.if_id_pc_plus1 = pc_plus1_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.issued_count   = count_q;
  assign state_o            = state_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, run, stall, redirect, wrap,
// saturation and reset during flush.
module tb_instr_fetch_unit;
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic       clk;
  logic       rst;
  logic [1:0] state;
  logic [15:0] imem [256];
  int pass_cnt  = 0;
  int total_cnt = 0;

  instr_fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus ();

  instr_fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(0)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  assign bus.imem_data = imem[bus.imem_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bundle: instr, opcode, pc_plus1, valid, imem_addr, count, state
  function automatic logic [54:0] snap();
    return {bus.if_id_instr, bus.if_id_opcode, bus.if_id_pc_plus1,
            bus.if_id_valid, bus.imem_addr, bus.issued_count, state};
  endfunction

  function automatic logic [54:0] mk(logic [15:0] instr, logic [3:0] op,
                                     logic [7:0] pp1, logic v, logic [7:0] addr,
                                     logic [15:0] cnt, logic [1:0] st);
    return {instr, op, pp1, v, addr, cnt, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic r, logic s, logic rd, logic [7:0] rpc);
    rst = r; bus.stall = s; bus.redirect = rd; bus.redirect_pc = rpc;
  endtask

  task automatic test_reset();
    logic [54:0] exp;
    drive(1'b1, 1'b1, 1'b1, 8'h55);
    tick();
    exp = mk(16'h0, 4'h0, 8'h00, 1'b0, 8'h00, 16'd0, S_BOOT);
    total_cnt++;
    if (snap() !== exp) $display("FAIL reset: got %h exp %h", snap(), exp);
    else pass_cnt++;
  endtask

  task automatic test_run();
    logic [54:0] exp;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int n = 0; n < 5; n++) begin
      tick();
      exp = mk(16'h1000 + 16'(n), 4'h1, 8'(n + 1), 1'b1, 8'(n + 1),
               16'(n + 1), S_RUN);
      total_cnt++;
      if (snap() !== exp) $display("FAIL run[%0d]: got %h exp %h", n, snap(), exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    logic [54:0] exp;
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    for (int n = 0; n < 3; n++) begin
      tick();
      exp = mk(16'h1004, 4'h1, 8'h05, 1'b1, 8'h05, 16'd5, S_RUN);
      total_cnt++;
      if (snap() !== exp) $display("FAIL stall[%0d]: got %h exp %h", n, snap(), exp);
      else pass_cnt++;
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    exp = mk(16'h1005, 4'h1, 8'h06, 1'b1, 8'h06, 16'd6, S_RUN);
    total_cnt++;
    if (snap() !== exp) $display("FAIL stall_release: got %h exp %h", snap(), exp);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_redirect();
    logic [54:0] exp;
    drive(1'b0, 1'b0, 1'b1, 8'h40);
    tick();
    exp = mk(16'h0, 4'h0, 8'h00, 1'b0, 8'h40, 16'd7, S_FLUSH);
    total_cnt++;
    if (snap() !== exp) $display("FAIL redirect_bubble: got %h exp %h", snap(), exp);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    exp = mk(16'hA040, 4'hA, 8'h41, 1'b1, 8'h41, 16'd8, S_RUN);
    total_cnt++;
    if (snap() !== exp) $display("FAIL redirect_target: got %h exp %h", snap(), exp);
    else pass_cnt++;
  endtask

  task automatic test_redirect_stall();
    logic [54:0] exp;
    drive(1'b0, 1'b1, 1'b1, 8'h20);
    tick();
    exp = mk(16'h0, 4'h0, 8'h00, 1'b0, 8'h20, 16'd8, S_FLUSH);
    total_cnt++;
    if (snap() !== exp) $display("FAIL redirect_over_stall: got %h exp %h", snap(), exp);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    exp = mk(16'h7020, 4'h7, 8'h21, 1'b1, 8'h21, 16'd9, S_RUN);
    total_cnt++;
    if (snap() !== exp) $display("FAIL redirect_stall_fetch: got %h exp %h", snap(), exp);
    else pass_cnt++;
  endtask

  task automatic test_flush_wrap();
    logic [54:0] exp;
    drive(1'b0, 1'b0, 1'b1, 8'h10);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    tick();
    exp = mk(16'h0, 4'h0, 8'h00, 1'b0, 8'hFF, 16'd9, S_FLUSH);
    total_cnt++;
    if (snap() !== exp) $display("FAIL double_redirect: got %h exp %h", snap(), exp);
    else pass_cnt++;
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    total_cnt++;
    if (snap() !== exp) $display("FAIL flush_stall: got %h exp %h", snap(), exp);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    exp = mk(16'h10FF, 4'h1, 8'h00, 1'b1, 8'h00, 16'd10, S_RUN);
    total_cnt++;
    if (snap() !== exp) $display("FAIL pc_wrap: got %h exp %h", snap(), exp);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_flush();
    logic [54:0] exp;
    drive(1'b0, 1'b0, 1'b1, 8'h30);
    tick();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    exp = mk(16'h0, 4'h0, 8'h00, 1'b0, 8'h00, 16'd0, S_BOOT);
    total_cnt++;
    if (snap() !== exp) $display("FAIL reset_in_flush: got %h exp %h", snap(), exp);
    else pass_cnt++;
    drive(1'b0, 1'b1, 1'b1, 8'h77);
    tick();
    exp = mk(16'h1000, 4'h1, 8'h01, 1'b1, 8'h01, 16'd1, S_RUN);
    total_cnt++;
    if (snap() !== exp) $display("FAIL boot_ignores_inputs: got %h exp %h", snap(), exp);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int n = 0; n < 16'hFFFE; n++) tick();
    total_cnt++;
    if (bus.issued_count !== 16'hFFFE)
      $display("FAIL count_preset: got %h exp %h", bus.issued_count, 16'hFFFE);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.issued_count !== 16'hFFFF)
      $display("FAIL count_max: got %h exp %h", bus.issued_count, 16'hFFFF);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.issued_count !== 16'hFFFF)
      $display("FAIL count_saturate: got %h exp %h", bus.issued_count, 16'hFFFF);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h1000 + 16'(i);
    imem[8'h40] = 16'hA040;
    imem[8'h20] = 16'h7020;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_flush_wrap();
    test_reset_in_flush();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
